uart_loader: RTL and testbench
==============================

# uart_loader

Host-facing loader sitting upstream of the CPU core. It parses a byte-serial command stream from the UART receiver to write and read back the 512×8 program RAM. It then pulses the CPU start input with an entry address and owns the UART transmitter until the CPU takes over. While the CPU runs, the loader ignores host traffic and sets `busy`, which the top level uses to select whose `tx_byte`/`transmit` reach the UART.

## Interface
Parameters:
- `ACK_OK`, default 8'h2B (`+`): acknowledge byte for a completed command.
- `ACK_ERR`, default 8'h3F (`?`): response to an unknown command byte.
- `ACK_BAD`, default 8'h21 (`!`): response to a checksum mismatch (only with `UART_LOADER_CSUM_EN`).

Ports:
- `clk` input 1: single system clock.
- `rst` input 1: reset, synchronous, active-high.
- `rx_byte` input 8: received UART byte, valid when `received`=1.
- `received` input 1: one-cycle strobe per received byte.
- `is_transmitting` input 1: UART transmitter busy.
- `tx_byte` output 8: byte to transmit.
- `transmit` output 1: one-cycle transmit strobe.
- `l_waddr` output 9: RAM write address.
- `dwrite` output 8: RAM write data.
- `write_en` output 1: RAM write enable, one cycle per byte.
- `l_raddr` output 9: RAM read address.
- `dread` input 8: RAM read data, valid 2 cycles after `l_raddr` changes.
- `cpu_start` output 1: one-cycle pulse into the CPU start input.
- `startaddr` output 9: CPU entry address, held stable from the start pulse until `halted`.
- `halted` input 1: CPU halt strobe.
- `busy` output 1: high from `cpu_start` until `halted`.

## Operation
- Commands (all addresses 9-bit: low bit of `ah` = A[8], `al` = A[7:0]):
  - `W` (0x57) `ah` `al` `n` followed by n data bytes: write data to RAM. `n`=0 means 256 bytes.
  - `R` (0x52) `ah` `al` `n`: read n bytes (0 → 256) and transmit each.
  - `X` (0x58) `ah` `al`: start the CPU at the given address.
- FSM states: IDLE, ADRH, ADRL, CNT, DATA, [CSUM], RDADR, RDWAIT, RDSEND, ACK, RUN.
- IDLE:
  - `W`, `R`, `X` → ADRH.
  - Any other byte → ACK sending `ACK_ERR`.
- ADRH/ADRL/CNT: latch one byte per `received`.
  - `X` skips CNT and goes ADRL → RUN.
- DATA: on each `received`, write at the current address, then increment the address modulo 512 (0x1FF wraps to 0x000). After the last byte → ACK (`ACK_OK`), or → CSUM when the macro is defined.
- R path: RDADR drives `l_raddr`; RDWAIT covers 2 cycles; RDSEND waits for `!is_transmitting`, then sends `dread`. Repeat with address+1 (mod 512) until the count is exhausted, then → ACK (`ACK_OK`).
- ACK: wait for `!is_transmitting`, pulse `transmit`, → IDLE.
- RUN: `cpu_start`=1 for exactly one cycle on entry, `busy`=1. All `received` strobes are ignored. `halted` → IDLE with no acknowledge byte sent.
- Bytes arriving while the loader waits on the transmitter (ACK, RDSEND) are dropped.
- The byte count is a 9-bit down-counter loaded with {n==0, n}.

## Timing
- Reset values: `tx_byte`=0, `transmit`=0, `l_waddr`=0, `l_raddr`=0, `dwrite`=0, `write_en`=0, `cpu_start`=0, `startaddr`=0, `busy`=0; state = IDLE.
- Reset asserted mid-command aborts with no write and no transmit on the following cycle. `rst` has priority over every other input.
- `write_en`, `l_waddr` and `dwrite` are registered and asserted in the cycle after the `received` strobe.
- After any `transmit` pulse, the loader waits one dead cycle before sampling `is_transmitting` again, to cover the UART's 1-cycle busy latency.
- If `received` and `halted` coincide, `halted` wins and the byte is dropped.

## Configuration
- `UART_LOADER_CSUM_EN` defined:
  - `W` takes one trailing checksum byte: the 8-bit sum (mod 256) of the data bytes.
  - Match → `ACK_OK`; mismatch → `ACK_BAD`. Data is already written either way.
- Not defined: no CSUM state, and `W` always ends with `ACK_OK`.

## Structure
- Shared package `loader_pkg`: the state enum, command byte constants (`CMD_W`, `CMD_R`, `CMD_X`), and `ADDR_W`=9.
- One sub-module, `uart_tx_arb`: implements the wait-for-idle, strobe and dead-cycle logic, shared by ACK and RDSEND.
- Address and count registers live in the top FSM.

## Test plan
- `W` 00 10 03 AA BB CC → `write_en` 3×, at 0x010/0x011/0x012 with AA/BB/CC; then `+` transmitted.
- `W` 01 FF 02 11 22 → writes 0x1FF=11 and 0x000=22 (wrap); then `+`.
- `R` 00 10 03 after the first test → transmits AA, BB, CC, `+`, with `is_transmitting` held 20 cycles per byte and no byte lost.
- `Q` → `?`; then `X` 00 10 → `cpu_start` one cycle with `startaddr`=0x010 and `busy`=1; byte 0x57 sent while busy is ignored; `halted` → `busy`=0.
- `rst` asserted after `W` 00 20 → next `W` 00 30 01 5A writes 0x030 only.
- With the macro: `W` 00 00 02 01 02 03 → `+`; same with checksum 04 → `!`.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared states, command bytes and widths for uart_loader (CSUM state only with UART_LOADER_CSUM_EN).
package loader_pkg;
  localparam int ADDR_W = 9;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_X = 8'h58;
  typedef enum logic [3:0] {
    IDLE, ADRH, ADRL, CNT, DATA,
`ifdef UART_LOADER_CSUM_EN
    CSUM,
`endif
    RDADR, RDWAIT, RDSEND, ACK, RUN
  } state_e;
  typedef enum logic [1:0] {ACK_C_OK, ACK_C_ERR, ACK_C_BAD} ack_e;
endpackage

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: waits for an idle transmitter, strobes one byte, then holds off while UART busy catches up.
module uart_tx_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       transmit,
  output logic       sent
);
  logic       transmit_q, transmit_d, dead_q, dead_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  always_comb begin
    sent       = req && !is_transmitting && !transmit_q && !dead_q;
    transmit_d = sent;
    dead_d     = transmit_q;
    tx_byte_d  = sent ? data : tx_byte_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      transmit_q <= 1'b0;
      dead_q     <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      transmit_q <= transmit_d;
      dead_q     <= dead_d;
      tx_byte_q  <= tx_byte_d;
    end
  end
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;
endmodule

// File: rtl/uart_loader.sv
// uart_loader: byte-serial W/R/X command parser loading program RAM and starting the CPU.
// Define UART_LOADER_CSUM_EN to require a trailing sum byte on W commands.
module uart_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] ACK_OK  = 8'h2B,
  parameter logic [7:0] ACK_ERR = 8'h3F,
  parameter logic [7:0] ACK_BAD = 8'h21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              received,
  input  logic              is_transmitting,
  output logic [7:0]        tx_byte,
  output logic              transmit,
  output logic [ADDR_W-1:0] l_waddr,
  output logic [7:0]        dwrite,
  output logic              write_en,
  output logic [ADDR_W-1:0] l_raddr,
  input  logic [7:0]        dread,
  output logic              cpu_start,
  output logic [ADDR_W-1:0] startaddr,
  input  logic              halted,
  output logic              busy
);
  state_e            state_q, state_d;
  ack_e              ack_q, ack_d;
  logic [7:0]        cmd_q, cmd_d, dwrite_q, dwrite_d, tx_data;
  logic [ADDR_W-1:0] addr_q, addr_d, l_waddr_q, l_waddr_d, l_raddr_q, l_raddr_d, startaddr_q, startaddr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              wait_q, wait_d, write_en_q, write_en_d, cpu_start_q, cpu_start_d, busy_q, busy_d;
  logic              tx_req, tx_sent;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    l_waddr_d   = l_waddr_q;
    dwrite_d    = dwrite_q;
    write_en_d  = 1'b0;
    l_raddr_d   = l_raddr_q;
    cpu_start_d = 1'b0;
    startaddr_d = startaddr_q;
    busy_d      = busy_q;
`ifdef UART_LOADER_CSUM_EN
    csum_d      = csum_q;
`endif
    tx_req  = state_q == ACK || state_q == RDSEND;
    tx_data = state_q == RDSEND ? dread :
              ack_q == ACK_C_ERR ? ACK_ERR :
              ack_q == ACK_C_BAD ? ACK_BAD : ACK_OK;
    case (state_q)
      IDLE: if (received) begin
        cmd_d   = rx_byte;
        ack_d   = ACK_C_ERR;
        state_d = (rx_byte == CMD_W || rx_byte == CMD_R || rx_byte == CMD_X) ? ADRH : ACK;
      end
      ADRH: if (received) begin
        addr_d  = {rx_byte[0], addr_q[7:0]};
        state_d = ADRL;
      end
      ADRL: if (received) begin
        addr_d = {addr_q[8], rx_byte};
        if (cmd_q == CMD_X) begin
          startaddr_d = {addr_q[8], rx_byte};
          cpu_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = RUN;
        end else state_d = CNT;
      end
      CNT: if (received) begin
        cnt_d   = {rx_byte == 8'd0, rx_byte};
        ack_d   = ACK_C_OK;
`ifdef UART_LOADER_CSUM_EN
        csum_d  = 8'd0;
`endif
        state_d = cmd_q == CMD_W ? DATA : RDADR;
      end
      DATA: if (received) begin
        write_en_d = 1'b1;
        l_waddr_d  = addr_q;
        dwrite_d   = rx_byte;
        addr_d     = addr_q + 9'd1;
        cnt_d      = cnt_q - 9'd1;
`ifdef UART_LOADER_CSUM_EN
        csum_d     = csum_q + rx_byte;
        if (cnt_q == 9'd1) state_d = CSUM;
`else
        if (cnt_q == 9'd1) state_d = ACK;
`endif
      end
`ifdef UART_LOADER_CSUM_EN
      CSUM: if (received) begin
        ack_d   = rx_byte == csum_q ? ACK_C_OK : ACK_C_BAD;
        state_d = ACK;
      end
`endif
      RDADR: begin
        l_raddr_d = addr_q;
        wait_d    = 1'b0;
        state_d   = RDWAIT;
      end
      RDWAIT: begin
        wait_d = 1'b1;
        if (wait_q) state_d = RDSEND;
      end
      RDSEND: if (tx_sent) begin
        addr_d  = addr_q + 9'd1;
        cnt_d   = cnt_q - 9'd1;
        state_d = cnt_q == 9'd1 ? ACK : RDADR;
      end
      ACK: if (tx_sent) state_d = IDLE;
      RUN: if (halted) begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ack_q       <= ACK_C_OK;
      cmd_q       <= 8'h00;
      addr_q      <= '0;
      cnt_q       <= '0;
      wait_q      <= 1'b0;
      l_waddr_q   <= '0;
      dwrite_q    <= 8'h00;
      write_en_q  <= 1'b0;
      l_raddr_q   <= '0;
      cpu_start_q <= 1'b0;
      startaddr_q <= '0;
      busy_q      <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      l_waddr_q   <= l_waddr_d;
      dwrite_q    <= dwrite_d;
      write_en_q  <= write_en_d;
      l_raddr_q   <= l_raddr_d;
      cpu_start_q <= cpu_start_d;
      startaddr_q <= startaddr_d;
      busy_q      <= busy_d;
`ifdef UART_LOADER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end
  uart_tx_arb u_tx_arb (
    .clk             (clk),
    .rst             (rst),
    .req             (tx_req),
    .data            (tx_data),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .sent            (tx_sent)
  );
  assign l_waddr   = l_waddr_q;
  assign dwrite    = dwrite_q;
  assign write_en  = write_en_q;
  assign l_raddr   = l_raddr_q;
  assign cpu_start = cpu_start_q;
  assign startaddr = startaddr_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: scoreboard bench for uart_loader with a 2-cycle-latency RAM and a slow UART transmitter model.
module tb_uart_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       received = 1'b0;
  logic       is_transmitting;
  logic [7:0] tx_byte;
  logic       transmit;
  logic [8:0] l_waddr, l_raddr, startaddr;
  logic [7:0] dwrite, dread, rd_d1;
  logic       write_en, cpu_start, busy;
  logic       halted = 1'b0;
  logic [7:0] mem [512];
  int         tx_cnt = 0;
  int         errors = 0;
  int         checks = 0;
  logic [16:0] exp_wr[$];
  logic [7:0]  exp_tx[$];

  always #5 clk = ~clk;

  uart_loader dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .l_waddr(l_waddr), .dwrite(dwrite), .write_en(write_en), .l_raddr(l_raddr),
    .dread(dread), .cpu_start(cpu_start), .startaddr(startaddr), .halted(halted), .busy(busy)
  );

  initial for (int i = 0; i < 512; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (write_en) mem[l_waddr] <= dwrite;
    rd_d1 <= mem[l_raddr];
    dread <= rd_d1;
    if (transmit) tx_cnt <= 20;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign is_transmitting = tx_cnt != 0;

  always @(negedge clk) begin
    logic [16:0] ew;
    logic [7:0]  et;
    if (write_en) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%h data=%h", l_waddr, dwrite);
      end else begin
        ew = exp_wr.pop_front();
        if ({l_waddr, dwrite} !== ew) begin
          errors++;
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h", l_waddr, dwrite, ew[16:8], ew[7:0]);
        end
      end
    end
    if (transmit) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected byte=%h", tx_byte);
      end else begin
        et = exp_tx.pop_front();
        if (tx_byte !== et) begin
          errors++;
          $display("FAIL tx got=%h expected=%h", tx_byte, et);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    @(negedge clk);
  endtask

  task automatic exp_w(input logic [8:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && (exp_wr.size() != 0 || exp_tx.size() != 0); i++) @(negedge clk);
    checks++;
    if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending_writes=%0d pending_tx=%0d required=0", name, exp_wr.size(), exp_tx.size());
      exp_wr.delete();
      exp_tx.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_byte, transmit, write_en, cpu_start, busy} !== 12'h0) begin
      errors++;
      $display("FAIL reset_tx tx_byte=%h transmit=%b write_en=%b cpu_start=%b busy=%b required all 0", tx_byte, transmit, write_en, cpu_start, busy);
    end
    checks++;
    if ({l_waddr, l_raddr, startaddr} !== 27'h0) begin
      errors++;
      $display("FAIL reset_addr waddr=%h raddr=%h startaddr=%h required 0", l_waddr, l_raddr, startaddr);
    end
    checks++;
    if (dwrite !== 8'h00) begin
      errors++;
      $display("FAIL reset_dwrite got=%h required=00", dwrite);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    exp_w(9'h010, 8'hAA); exp_w(9'h011, 8'hBB); exp_w(9'h012, 8'hCC);
    exp_tx.push_back(8'h2B);
    send(8'h57); send(8'h00); send(8'h10); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
`ifdef UART_LOADER_CSUM_EN
    send(8'h31);
`endif
    drain("write");
  endtask

  task automatic test_wrap;
    exp_w(9'h1FF, 8'h11); exp_w(9'h000, 8'h22);
    exp_tx.push_back(8'h2B);
    send(8'h57); send(8'h01); send(8'hFF); send(8'h02); send(8'h11); send(8'h22);
`ifdef UART_LOADER_CSUM_EN
    send(8'h33);
`endif
    drain("wrap");
  endtask

  task automatic test_read;
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'hBB); exp_tx.push_back(8'hCC); exp_tx.push_back(8'h2B);
    send(8'h52); send(8'h00); send(8'h10); send(8'h03);
    drain("read");
  endtask

  task automatic test_run;
    exp_tx.push_back(8'h3F);
    send(8'h51);
    drain("bad_cmd");
    send(8'h58); send(8'h00);
    @(negedge clk);
    rx_byte  = 8'h10;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    checks++;
    if ({cpu_start, busy, startaddr} !== {2'b11, 9'h010}) begin
      errors++;
      $display("FAIL run_start cpu_start=%b busy=%b startaddr=%h required 1 1 010", cpu_start, busy, startaddr);
    end
    @(negedge clk);
    checks++;
    if ({cpu_start, busy} !== 2'b01) begin
      errors++;
      $display("FAIL run_pulse cpu_start=%b busy=%b required 0 1", cpu_start, busy);
    end
    send(8'h57); send(8'h00); send(8'h40); send(8'h01); send(8'h5A); send(8'h51);
    repeat (30) @(negedge clk);
    checks++;
    if ({busy, startaddr} !== {1'b1, 9'h010}) begin
      errors++;
      $display("FAIL run_hold busy=%b startaddr=%h required 1 010", busy, startaddr);
    end
    halted   = 1'b1;
    rx_byte  = 8'h51;
    received = 1'b1;
    @(negedge clk);
    halted   = 1'b0;
    received = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL run_halt busy=%b required 0", busy);
    end
    repeat (40) @(negedge clk);
    exp_tx.push_back(8'h3F);
    send(8'h51);
    drain("after_halt");
  endtask

  task automatic test_reset_mid;
    send(8'h57); send(8'h00); send(8'h20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({write_en, transmit, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid write_en=%b transmit=%b busy=%b required 0", write_en, transmit, busy);
    end
    exp_w(9'h030, 8'h5A);
    exp_tx.push_back(8'h2B);
    send(8'h57); send(8'h00); send(8'h30); send(8'h01); send(8'h5A);
`ifdef UART_LOADER_CSUM_EN
    send(8'h5A);
`endif
    drain("reset_mid");
  endtask

`ifdef UART_LOADER_CSUM_EN
  task automatic test_csum;
    exp_w(9'h000, 8'h01); exp_w(9'h001, 8'h02);
    exp_tx.push_back(8'h2B);
    send(8'h57); send(8'h00); send(8'h00); send(8'h02); send(8'h01); send(8'h02); send(8'h03);
    drain("csum_ok");
    exp_w(9'h000, 8'h01); exp_w(9'h001, 8'h02);
    exp_tx.push_back(8'h21);
    send(8'h57); send(8'h00); send(8'h00); send(8'h02); send(8'h01); send(8'h02); send(8'h04);
    drain("csum_bad");
  endtask
`endif

  task automatic test_count_zero;
    logic [7:0] sum = 8'h00;
    for (int i = 0; i < 256; i++) exp_w(9'(9'h180 + i), 8'(i) ^ 8'h5C);
    exp_tx.push_back(8'h2B);
    send(8'h57); send(8'h01); send(8'h80); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i) ^ 8'h5C);
      sum = sum + (8'(i) ^ 8'h5C);
    end
`ifdef UART_LOADER_CSUM_EN
    send(sum);
`endif
    drain("count_zero");
    exp_tx.push_back(8'h7E ^ 8'h5C); exp_tx.push_back(8'h7F ^ 8'h5C); exp_tx.push_back(8'h80 ^ 8'h5C);
    exp_tx.push_back(8'h2B);
    send(8'h52); send(8'h01); send(8'hFE); send(8'h03);
    drain("read_wrap");
  endtask

  initial begin
    test_reset;
    test_write;
    test_wrap;
    test_read;
    test_run;
    test_reset_mid;
`ifdef UART_LOADER_CSUM_EN
    test_csum;
`endif
    test_count_zero;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
